// File: rtl/vga_stream_monitor.sv
// Rebuilds VGA line/frame timing from sampled HS/VS/BLANK_N, checks it against the
// configured geometry, and checksums the active pixels of every frame.
module vga_stream_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_ce,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        locked,
  output logic        frame_done,
  output logic [31:0] frame_checksum,
  output logic [10:0] h_active_meas,
  output logic [9:0]  v_active_meas,
  output logic        err_htotal,
  output logic        err_hactive,
  output logic        err_vtotal,
  output logic        err_vactive,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state, state_nxt;

  logic        hs_act, vs_act, hs_prev, vs_prev, hs_edge, vs_edge;
  logic [10:0] line_cnt, act_cnt, line_act_last, last_eff;
  logic [9:0]  lines, act_lines, lines_eff, act_lines_eff;
  logic [31:0] acc, acc_eff;
  logic        f_htotal, f_hactive;
  logic        e_htotal, e_hactive, e_vtotal, e_vactive, any_err, close;

  assign hs_act  = (vga_hs == SYNC_POL);
  assign vs_act  = (vga_vs == SYNC_POL);
  assign hs_edge = pix_ce && hs_act && !hs_prev;
  assign vs_edge = pix_ce && vs_act && !vs_prev;
  assign close   = vs_edge && (state != SEARCH);

  // The line ended by an HS edge is folded in before a coincident VS edge closes the frame.
  always_comb begin
    e_htotal      = f_htotal;
    e_hactive     = f_hactive;
    lines_eff     = lines;
    act_lines_eff = act_lines;
    last_eff      = line_act_last;
    acc_eff       = acc;
    if (hs_edge) begin
      if (({1'b0, line_cnt} + 12'd1) != 12'(H_TOTAL))
        e_htotal = 1'b1;
      if (lines != 10'h3FF)
        lines_eff = lines + 10'd1;
      if (act_cnt != 11'd0) begin
        last_eff = act_cnt;
        if (act_lines != 10'h3FF)
          act_lines_eff = act_lines + 10'd1;
        if (act_cnt != 11'(H_ACTIVE))
          e_hactive = 1'b1;
      end
    end
    if (vga_blank_n)
      acc_eff = acc + {8'h00, vga_r, vga_g, vga_b};
    e_vtotal  = (lines_eff != 10'(V_TOTAL));
    e_vactive = (act_lines_eff != 10'(V_ACTIVE));
    any_err   = e_htotal | e_hactive | e_vtotal | e_vactive;
  end

  always_comb begin
    state_nxt = state;
    if (vs_edge) begin
      case (state)
        SEARCH:  state_nxt = MEASURE;
        MEASURE: state_nxt = any_err ? MEASURE : LOCKED;
        LOCKED:  state_nxt = any_err ? MEASURE : LOCKED;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // Sync history resets to "asserted" so restarting inside a sync pulse cannot fake an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_prev       <= 1'b1;
      vs_prev       <= 1'b1;
      line_cnt      <= '0;
      act_cnt       <= '0;
      line_act_last <= '0;
      lines         <= '0;
      act_lines     <= '0;
      acc           <= '0;
      f_htotal      <= 1'b0;
      f_hactive     <= 1'b0;
    end else if (pix_ce) begin
      hs_prev       <= hs_act;
      vs_prev       <= vs_act;
      line_act_last <= last_eff;
      if (hs_edge)
        line_cnt <= '0;
      else if (line_cnt != 11'h7FF)
        line_cnt <= line_cnt + 11'd1;
      if (hs_edge)
        act_cnt <= '0;
      else if (vga_blank_n && act_cnt != 11'h7FF)
        act_cnt <= act_cnt + 11'd1;
      if (vs_edge) begin
        lines     <= '0;
        act_lines <= '0;
        acc       <= '0;
        f_htotal  <= 1'b0;
        f_hactive <= 1'b0;
      end else begin
        lines     <= lines_eff;
        act_lines <= act_lines_eff;
        acc       <= acc_eff;
        f_htotal  <= e_htotal;
        f_hactive <= e_hactive;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= SEARCH;
      locked         <= 1'b0;
      frame_done     <= 1'b0;
      frame_checksum <= '0;
      h_active_meas  <= '0;
      v_active_meas  <= '0;
      err_htotal     <= 1'b0;
      err_hactive    <= 1'b0;
      err_vtotal     <= 1'b0;
      err_vactive    <= 1'b0;
      err_count      <= '0;
    end else begin
      state      <= state_nxt;
      locked     <= (state_nxt == LOCKED);
      frame_done <= close;
      if (close) begin
        frame_checksum <= acc_eff;
        h_active_meas  <= last_eff;
        v_active_meas  <= act_lines_eff;
        err_htotal     <= e_htotal;
        err_hactive    <= e_hactive;
        err_vtotal     <= e_vtotal;
        err_vactive    <= e_vactive;
        if (any_err && err_count != 8'hFF)
          err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
